// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller for a classic 5-stage in-order pipeline.
// Resolves taken branches (flush IF/ID and ID/EX, redirect PC), load-use
// hazards (one-cycle stall with an ID/EX bubble) and HALT (stop fetch, let
// EX/MEM/WB drain for DrainCycles cycles, then freeze).
//
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   id_rs, id_rt      source registers of the ID instruction
//   id_uses_rt        ID instruction actually reads id_rt
//   id_halt           ID instruction is HALT
//   ex_mem_read       EX instruction is a load
//   ex_rd             EX destination register
//   ex_branch_taken   branch resolved taken in EX
//   pc_write          PC enable
//   ifid_write        IF/ID enable
//   ifid_flush        bubble into IF/ID
//   idex_flush        bubble into ID/EX
//   pc_src            1 = PC loads branch target
//   halted            registered, pipeline fully drained
//   stall_count       saturating count of load-use stalls
//   cycle_count       cycles executed (RUN + DRAIN), wraps
module pipeline_hazard_controller #(
    parameter int RegAddrBits = 3,
    parameter int DrainCycles = 3,
    parameter int CountWidth  = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [RegAddrBits-1:0] id_rs,
    input  logic [RegAddrBits-1:0] id_rt,
    input  logic                   id_uses_rt,
    input  logic                   id_halt,
    input  logic                   ex_mem_read,
    input  logic [RegAddrBits-1:0] ex_rd,
    input  logic                   ex_branch_taken,
    output logic                   pc_write,
    output logic                   ifid_write,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   pc_src,
    output logic                   halted,
    output logic [7:0]             stall_count,
    output logic [CountWidth-1:0]  cycle_count
);

    localparam int DW = (DrainCycles > 1) ? $clog2(DrainCycles) : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            load_use;
    logic            stall_inc;

    // Register 0 is hardwired zero, so a load targeting it never creates a
    // dependency. rt only matters when the ID instruction reads it.
    assign load_use = ex_mem_read && (ex_rd != '0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        stall_inc  = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        pc_src     = 1'b0;

        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    // Redirect wins; the hazard/halt belong to wrong-path
                    // instructions that are being squashed anyway.
                    pc_src     = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (load_use) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    idex_flush = 1'b1;
                    stall_inc  = 1'b1;
                end else if (id_halt) begin
                    // HALT moves on to EX; nothing behind it may enter.
                    pc_write   = 1'b0;
                    ifid_flush = 1'b1;
                    state_d    = DRAIN;
                    drain_d    = DW'(DrainCycles - 1);
                end
            end
            DRAIN: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                if (drain_q == '0) state_d = HALTED;
                else               drain_d = drain_q - 1'b1;
            end
            HALTED: begin
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            default: state_d = RUN;
        endcase

        // While reset is held the pipeline must look like a plain RUN cycle,
        // whatever state the register currently holds.
        if (!RST) begin
            pc_write   = 1'b1;
            ifid_write = 1'b1;
            ifid_flush = 1'b0;
            idex_flush = 1'b0;
            pc_src     = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= RUN;
            drain_q     <= '0;
            halted      <= 1'b0;
            stall_count <= '0;
            cycle_count <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            halted  <= (state_d == HALTED);
            if (stall_inc && (stall_count != 8'hFF))
                stall_count <= stall_count + 8'd1;
            if (state_q != HALTED)
                cycle_count <= cycle_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
module tb_pipeline_hazard_controller;

    logic        CLK = 1'b0;
    logic        RST;
    logic [2:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, id_halt, ex_mem_read, ex_branch_taken;
    logic        pc_write, ifid_write, ifid_flush, idex_flush, pc_src, halted;
    logic [7:0]  stall_count;
    logic [15:0] cycle_count;
    logic [4:0]  ctl;

    int n_vec  = 0;
    int n_fail = 0;

    // ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pc_src}
    localparam logic [4:0] NORM  = 5'b11000;
    localparam logic [4:0] STALL = 5'b00010;
    localparam logic [4:0] BRNCH = 5'b11111;
    localparam logic [4:0] HALTC = 5'b01100;
    localparam logic [4:0] HLTD  = 5'b00110;
    localparam logic [4:0] ALL   = 5'b11111;
    localparam logic [4:0] DRM   = 5'b10111; // ifid_write not constrained in DRAIN

    pipeline_hazard_controller #(.RegAddrBits(3), .DrainCycles(3), .CountWidth(16)) dut (
        .CLK(CLK), .RST(RST), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .id_halt(id_halt), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .ex_branch_taken(ex_branch_taken), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pc_src(pc_src),
        .halted(halted), .stall_count(stall_count), .cycle_count(cycle_count)
    );

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pc_src};

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [4:0] mask;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string      name;
        logic [2:0] rs, rt;
        logic       uses_rt, halt, mr;
        logic [2:0] rd;
        logic       br;
        logic [4:0] exp_ctl;
        logic       exp_inc;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic [2:0] rs, input logic [2:0] rt, input logic uses,
                          input logic halt, input logic mr, input logic [2:0] rd,
                          input logic br);
        id_rs = rs; id_rt = rt; id_uses_rt = uses; id_halt = halt;
        ex_mem_read = mr; ex_rd = rd; ex_branch_taken = br;
    endtask

    task automatic expect_ctl(input string n, input logic [4:0] c, input logic [4:0] m);
        exp_t e;
        e.name = n; e.ctl = c; e.mask = m;
        sbq.push_back(e);
    endtask

    // Combinational outputs are sampled mid-cycle, away from the edge.
    task automatic check_ctl();
        exp_t e;
        @(negedge CLK);
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.name, 32'(ctl & e.mask), 32'(e.ctl & e.mask));
        end
    endtask

    task automatic reset_dut();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        RST = 1'b0;
        tick();
        tick();
        RST = 1'b1;
    endtask

    vec_t vecs[10];
    int   exp_stall;

    initial begin
        vecs[0] = '{"normal",       3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, NORM,  1'b0};
        vecs[1] = '{"lu_rs",        3'd3, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, STALL, 1'b1};
        vecs[2] = '{"lu_rd0",       3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, NORM,  1'b0};
        vecs[3] = '{"rt_unused",    3'd1, 3'd3, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, NORM,  1'b0};
        vecs[4] = '{"lu_rt",        3'd1, 3'd3, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0, STALL, 1'b1};
        vecs[5] = '{"no_load",      3'd3, 3'd3, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, NORM,  1'b0};
        vecs[6] = '{"branch",       3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, BRNCH, 1'b0};
        vecs[7] = '{"collision",    3'd4, 3'd0, 1'b0, 1'b1, 1'b1, 3'd4, 1'b1, BRNCH, 1'b0};
        vecs[8] = '{"post_collide", 3'd1, 3'd2, 1'b1, 1'b0, 1'b0, 3'd6, 1'b0, NORM,  1'b0};
        vecs[9] = '{"lu_over_halt", 3'd7, 3'd0, 1'b0, 1'b1, 1'b1, 3'd7, 1'b0, STALL, 1'b1};

        // Reset: hostile inputs while RST is low must not leak through.
        set_in(3'd3, 3'd3, 1'b1, 1'b1, 1'b1, 3'd3, 1'b1);
        RST = 1'b0;
        expect_ctl("rst_ctl", NORM, ALL);
        check_ctl();
        tick();
        tick();
        RST = 1'b1;
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_stall", 32'(stall_count), 32'd0);
        chk("rst_cycle", 32'(cycle_count), 32'd0);
        expect_ctl("post_rst_ctl", NORM, ALL);
        check_ctl();
        tick();
        chk("first_cycle", 32'(cycle_count), 32'd1);

        // Table of single-cycle RUN vectors.
        exp_stall = 0;
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].rs, vecs[i].rt, vecs[i].uses_rt, vecs[i].halt,
                   vecs[i].mr, vecs[i].rd, vecs[i].br);
            expect_ctl(vecs[i].name, vecs[i].exp_ctl, ALL);
            check_ctl();
            tick();
            if (vecs[i].exp_inc) exp_stall++;
            chk({vecs[i].name, "_stall"}, 32'(stall_count), 32'(exp_stall));
        end

        // Halt at cycle 10 -> halted at cycle 14, count frozen.
        reset_dut();
        repeat (10) tick();
        chk("pre_halt_cycle", 32'(cycle_count), 32'd10);
        set_in(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        expect_ctl("halt_ctl", HALTC, ALL);
        check_ctl();
        tick();
        // Inputs during drain must be ignored.
        set_in(3'd2, 3'd2, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
        for (int k = 11; k < 14; k++) begin
            expect_ctl("drain_ctl", 5'b00110, DRM);
            check_ctl();
            chk("drain_halted", 32'(halted), 32'd0);
            tick();
        end
        chk("halted_at_14", 32'(halted), 32'd1);
        chk("cycle_at_14", 32'(cycle_count), 32'd14);
        for (int k = 0; k < 5; k++) begin
            expect_ctl("halted_ctl", HLTD, ALL);
            check_ctl();
            tick();
            chk("frozen_cycle", 32'(cycle_count), 32'd14);
            chk("halted_hold", 32'(halted), 32'd1);
        end
        chk("drain_no_stall", 32'(stall_count), 32'd0);

        // Reset out of HALTED, then saturation.
        reset_dut();
        chk("rst_from_halted", 32'(halted), 32'd0);
        chk("rst_from_halted_cyc", 32'(cycle_count), 32'd0);
        set_in(3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        repeat (254) tick();
        chk("stall_254", 32'(stall_count), 32'd254);
        repeat (6) tick();
        chk("stall_sat", 32'(stall_count), 32'd255);
        expect_ctl("sat_ctl", STALL, ALL);
        check_ctl();
        tick();
        chk("stall_sat_hold", 32'(stall_count), 32'd255);

        // Reset in the second DRAIN cycle.
        reset_dut();
        set_in(3'd5, 3'd0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
        tick();
        set_in(3'd0, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
        tick();
        set_in(3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
        tick();
        chk("mid_pre_stall", 32'(stall_count), 32'd1);
        RST = 1'b0;
        expect_ctl("mid_rst_ctl", NORM, ALL);
        check_ctl();
        tick();
        RST = 1'b1;
        chk("mid_halted", 32'(halted), 32'd0);
        chk("mid_cycle", 32'(cycle_count), 32'd0);
        chk("mid_stall", 32'(stall_count), 32'd0);
        expect_ctl("mid_run_ctl", NORM, ALL);
        check_ctl();
        tick();
        chk("mid_run_cycle", 32'(cycle_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
